// File: rtl/ddr3_buffer_sched_pkg.sv
// Shared definitions for the DDR3 frame-buffer read scheduler:
// state encoding and the DDR3 word-address width.
package ddr3_pkg;

  localparam int DDR3_ADDR_W = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/ddr3_buffer_sched.sv
// Ping-pong read scheduler: fetches each full DDR3 frame buffer in bursts,
// streams the beats to the pixel FIFO and pulses the matching clear when done.
module ddr3_buffer_sched
  import ddr3_pkg::*;
#(
  parameter int ADDR_W    = DDR3_ADDR_W,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16,
  parameter int BUF_WORDS = 4096,
  parameter int SPACE_W   = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sched_en,
  input  logic [1:0]        buffer_full,
  input  logic [ADDR_W-1:0] buffer0_offset,
  input  logic [ADDR_W-1:0] buffer1_offset,
  output logic              clear_buffer0,
  output logic              clear_buffer1,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [4:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic [SPACE_W-1:0] fifo_space,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              busy,
  output logic              cur_buf
);

  localparam int NUM_BURSTS = BUF_WORDS / BURST_LEN;
  localparam int BEAT_W     = $clog2(BURST_LEN);
  localparam int BIDX_W     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BIDX_W-1:0]  LAST_BURST = BIDX_W'(NUM_BURSTS - 1);
  localparam logic [SPACE_W:0]   MIN_SPACE  = (SPACE_W + 1)'(BURST_LEN);

  sched_state_t      state;
  sched_state_t      next_state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BIDX_W-1:0] burst_idx;
  logic              space_ok;
  logic              start_ok;
  logic              burst_end;
  logic              last_burst;
  logic [ADDR_W-1:0] base_addr;

  // A burst is only issued when the FIFO can absorb every beat, since
  // readdatavalid cannot be back-pressured.
  assign space_ok   = {1'b0, fifo_space} >= MIN_SPACE;
  assign start_ok   = sched_en && buffer_full[cur_buf] && space_ok;
  assign burst_end  = (state == DATA) && avm_readdatavalid && (beat_cnt == LAST_BEAT);
  assign last_burst = (burst_idx == LAST_BURST);
  assign base_addr  = cur_buf ? buffer1_offset : buffer0_offset;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_ok) next_state = REQ;
      REQ:  if (!avm_waitrequest) next_state = DATA;
      DATA: begin
        if (burst_end) begin
          if (last_burst)                next_state = DONE;
          else if (sched_en && space_ok) next_state = REQ;
          else                           next_state = IDLE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    avm_read       = 1'b0;
    avm_address    = '0;
    avm_burstcount = '0;
    clear_buffer0  = 1'b0;
    clear_buffer1  = 1'b0;
    busy           = (state != IDLE);
    case (state)
      REQ: begin
        avm_read       = 1'b1;
        avm_address    = base_addr + (ADDR_W'(burst_idx) << BEAT_W);
        avm_burstcount = 5'(BURST_LEN);
      end
      DONE: begin
        clear_buffer0 = !cur_buf;
        clear_buffer1 = cur_buf;
      end
      default: ;
    endcase
  end

  // Disabling mid-buffer restarts the buffer from its first burst; a low
  // FIFO with scheduling still enabled resumes at the next burst instead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt  <= '0;
      burst_idx <= '0;
      cur_buf   <= 1'b0;
    end else begin
      if (state == DATA && avm_readdatavalid) beat_cnt <= beat_cnt + 1'b1;
      if (burst_end && !last_burst) burst_idx <= sched_en ? burst_idx + 1'b1 : '0;
      if (state == DONE) begin
        burst_idx <= '0;
        cur_buf   <= ~cur_buf;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      pix_valid <= (state == DATA) && avm_readdatavalid;
      if (state == DATA && avm_readdatavalid) pix_data <= avm_readdata;
    end
  end

endmodule

// File: tb/tb_ddr3_buffer_sched.sv
// Scoreboard bench for ddr3_buffer_sched: a randomised Avalon slave feeds beats,
// a transaction-level model predicts addresses, pixels and buffer clears.
module tb_ddr3_buffer_sched;

  localparam int ADDR_W    = 26;
  localparam int DATA_W    = 64;
  localparam int BURST_LEN = 16;
  localparam int BUF_WORDS = 64;
  localparam int SPACE_W   = 10;
  localparam int NB        = BUF_WORDS / BURST_LEN;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              sched_en;
  logic [1:0]        buffer_full;
  logic [ADDR_W-1:0] buffer0_offset;
  logic [ADDR_W-1:0] buffer1_offset;
  logic              clear_buffer0;
  logic              clear_buffer1;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [4:0]        avm_burstcount;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic [SPACE_W-1:0] fifo_space;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              busy;
  logic              cur_buf;

  always #5 clk = ~clk;

  ddr3_buffer_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
    .BUF_WORDS(BUF_WORDS), .SPACE_W(SPACE_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sched_en(sched_en), .buffer_full(buffer_full),
    .buffer0_offset(buffer0_offset), .buffer1_offset(buffer1_offset),
    .clear_buffer0(clear_buffer0), .clear_buffer1(clear_buffer1),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .fifo_space(fifo_space),
    .pix_data(pix_data), .pix_valid(pix_valid), .busy(busy), .cur_buf(cur_buf)
  );

  int checks = 0;
  int errors = 0;

  // Model and monitor state (written only by the monitor process)
  bit                mbuf;
  int                mburst;
  int                mbeats;
  logic [DATA_W-1:0] pix_q[$];
  int                clr_q[$];
  logic [ADDR_W-1:0] acc_log[$];
  int                accept_cnt = 0;
  int                clr_cnt0 = 0;
  int                clr_cnt1 = 0;
  int                pix_cnt = 0;
  int                stall_run = 0;
  int                last_stall_run = 0;
  bit                prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  int                exp_id;
  logic [ADDR_W-1:0] exp_addr;

  // Slave state
  int seen_acc = 0;
  int beats_left = 0;
  int read_cycles = 0;
  bit stall_mode = 0;

  // Main-process bookkeeping
  int seen_clr0 = 0;
  int seen_clr1 = 0;
  int a0, c0, c1, p0;
  logic [SPACE_W-1:0] space_tab[5] = '{10'd4, 10'd15, 10'd16, 10'd100, 10'd512};

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The scoreboard model works per transaction: burst accepted, beat returned,
  // burst completed. Only buffer id and burst number are tracked.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mbuf = 0; mburst = 0; mbeats = 0;
        pix_q.delete(); clr_q.delete();
        prev_stall = 0; stall_run = 0;
      end else begin
        if (prev_stall) begin
          check_output("req_hold_read", avm_read, 1);
          check_output("req_hold_addr", avm_address, prev_addr);
        end
        if (clear_buffer0 || clear_buffer1) begin
          check_output("clear_onehot", {clear_buffer1, clear_buffer0} == 2'b11, 0);
          if (clr_q.size() == 0) check_output("clear_unexpected", {clear_buffer1, clear_buffer0}, 0);
          else begin
            exp_id = clr_q.pop_front();
            check_output("clear_id", {clear_buffer1, clear_buffer0}, (exp_id != 0) ? 2'b10 : 2'b01);
          end
          if (clear_buffer0) clr_cnt0++;
          if (clear_buffer1) clr_cnt1++;
        end
        if (pix_valid) begin
          pix_cnt++;
          if (pix_q.size() == 0) check_output("pix_unexpected", pix_valid, 0);
          else check_output("pix_data", pix_data, pix_q.pop_front());
        end
        if (avm_read && !avm_waitrequest) begin
          exp_addr = (mbuf ? buffer1_offset : buffer0_offset) + ADDR_W'(mburst * BURST_LEN);
          check_output("req_addr", avm_address, exp_addr);
          check_output("req_cur_buf", cur_buf, mbuf);
          check_output("req_burstcount", avm_burstcount, BURST_LEN);
          acc_log.push_back(avm_address);
          accept_cnt++;
          last_stall_run = stall_run;
        end
        stall_run = (avm_read && avm_waitrequest) ? stall_run + 1 : 0;
        if (avm_readdatavalid) begin
          pix_q.push_back(avm_readdata);
          mbeats++;
          if (mbeats == BURST_LEN) begin
            mbeats = 0;
            if (mburst == NB - 1) begin
              clr_q.push_back(int'(mbuf));
              mbuf = !mbuf;
              mburst = 0;
            end else if (!sched_en) mburst = 0;
            else mburst++;
          end
        end
        prev_stall = avm_read && avm_waitrequest;
        prev_addr = avm_address;
      end
    end
  end

  // Avalon slave: one burst at a time, random beat gaps, random or fixed stalls.
  initial begin
    avm_waitrequest = 1'b1;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset_n) begin
        beats_left = 0; read_cycles = 0; seen_acc = accept_cnt;
        avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
      end else begin
        if (accept_cnt != seen_acc) begin
          seen_acc = accept_cnt;
          beats_left = BURST_LEN;
        end
        read_cycles = avm_read ? read_cycles + 1 : 0;
        if (beats_left > 0 && $urandom_range(0, 3) != 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = {$urandom, $urandom};
          beats_left--;
        end else avm_readdatavalid = 1'b0;
        if (stall_mode) avm_waitrequest = (read_cycles <= 5);
        else avm_waitrequest = ($urandom_range(0, 2) == 0);
      end
    end
  end

  // The bench plays the CSR block: a clear pulse empties the buffer flag.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (clr_cnt0 != seen_clr0) begin seen_clr0 = clr_cnt0; buffer_full[0] = 1'b0; end
      if (clr_cnt1 != seen_clr1) begin seen_clr1 = clr_cnt1; buffer_full[1] = 1'b0; end
    end
  endtask

  task automatic apply_stimulus(input bit en, input logic [1:0] full, input logic [SPACE_W-1:0] space);
    sched_en = en;
    buffer_full = full;
    fifo_space = space;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    apply_stimulus(0, 2'b00, '0);
    stall_mode = 0;
    tick(3);
    reset_n = 1'b1;
    seen_clr0 = clr_cnt0;
    seen_clr1 = clr_cnt1;
    tick(1);
    a0 = accept_cnt; c0 = clr_cnt0; c1 = clr_cnt1; p0 = pix_cnt;
  endtask

  task automatic wait_accepts(input int target, input int budget, input string name);
    int n = 0;
    while (accept_cnt < target && n < budget) begin tick(1); n++; end
    check_output(name, accept_cnt >= target, 1);
  endtask

  task automatic wait_clears(input int target, input int budget, input string name);
    int n = 0;
    while ((clr_cnt0 + clr_cnt1) < target && n < budget) begin tick(1); n++; end
    check_output(name, (clr_cnt0 + clr_cnt1) >= target, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin tick(1); n++; end
    check_output(name, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    buffer0_offset = 26'h100;
    buffer1_offset = 26'h2000;
    reset_dut();

    check_output("reset_busy", busy, 0);
    check_output("reset_cur_buf", cur_buf, 0);
    check_output("reset_read", avm_read, 0);
    check_output("reset_addr", avm_address, 0);
    check_output("reset_pix_valid", pix_valid, 0);
    check_output("reset_pix_data", pix_data, 0);
    check_output("reset_clears", {clear_buffer1, clear_buffer0}, 0);

    // Single buffer, four bursts
    apply_stimulus(1, 2'b01, 10'd512);
    wait_clears(c0 + c1 + 1, 600, "t1_clear_timeout");
    tick(3);
    for (int i = 0; i < NB; i++)
      check_output("t1_addr_seq", (acc_log.size() > a0 + i) ? acc_log[a0 + i] : '1, 26'h100 + 26'(16 * i));
    check_output("t1_bursts", accept_cnt - a0, 4);
    check_output("t1_pix_count", pix_cnt - p0, 64);
    check_output("t1_clear0", clr_cnt0 - c0, 1);
    check_output("t1_cur_buf", cur_buf, 1);
    check_output("t1_idle", busy, 0);

    // Both buffers full, strict alternation 0,1,0
    reset_dut();
    apply_stimulus(1, 2'b11, 10'd512);
    wait_clears(c0 + c1 + 1, 600, "t2_first_clear_timeout");
    tick(2);
    buffer_full[0] = 1'b1;
    wait_clears(c0 + c1 + 3, 1500, "t2_clear_timeout");
    tick(3);
    check_output("t2_last_buf0_addr", (acc_log.size() > a0 + 3) ? acc_log[a0 + 3] : '1, 26'h130);
    check_output("t2_first_buf1_addr", (acc_log.size() > a0 + 4) ? acc_log[a0 + 4] : '1, 26'h2000);
    check_output("t2_bursts", accept_cnt - a0, 12);
    check_output("t2_clear0", clr_cnt0 - c0, 2);
    check_output("t2_clear1", clr_cnt1 - c1, 1);

    // Five-cycle waitrequest stall on every request
    reset_dut();
    stall_mode = 1;
    apply_stimulus(1, 2'b01, 10'd512);
    wait_accepts(a0 + 1, 100, "t3_accept_timeout");
    check_output("t3_stall_len", last_stall_run, 5);
    tick(1);
    check_output("t3_single_accept", accept_cnt - a0, 1);
    wait_clears(c0 + c1 + 1, 800, "t3_clear_timeout");
    check_output("t3_bursts", accept_cnt - a0, 4);
    stall_mode = 0;

    // Low FIFO space parks in IDLE, then resumes at the next burst
    reset_dut();
    apply_stimulus(1, 2'b01, 10'd512);
    wait_accepts(a0 + 1, 100, "t4_accept_timeout");
    fifo_space = 10'd15;
    wait_idle(300, "t4_park_timeout");
    tick(30);
    check_output("t4_no_read", accept_cnt - a0, 1);
    check_output("t4_parked", busy, 0);
    fifo_space = 10'd16;
    wait_accepts(a0 + 2, 100, "t4_resume_timeout");
    check_output("t4_resume_addr", (acc_log.size() > a0 + 1) ? acc_log[a0 + 1] : '1, 26'h110);
    wait_clears(c0 + c1 + 1, 600, "t4_clear_timeout");

    // Address wrap at the top of the DDR3 space
    reset_dut();
    buffer0_offset = 26'h3FFFFF8;
    apply_stimulus(1, 2'b01, 10'd512);
    wait_clears(c0 + c1 + 1, 600, "t5_clear_timeout");
    check_output("t5_addr0", (acc_log.size() > a0) ? acc_log[a0] : '0, 26'h3FFFFF8);
    check_output("t5_addr1_wrap", (acc_log.size() > a0 + 1) ? acc_log[a0 + 1] : '1, 26'h0000008);
    check_output("t5_addr3", (acc_log.size() > a0 + 3) ? acc_log[a0 + 3] : '1, 26'h0000028);

    // sched_en drops during burst 2: restart from burst 0 without a clear
    reset_dut();
    buffer0_offset = 26'h100;
    apply_stimulus(1, 2'b01, 10'd512);
    wait_accepts(a0 + 2, 200, "t6_accept_timeout");
    sched_en = 1'b0;
    wait_idle(300, "t6_idle_timeout");
    tick(20);
    check_output("t6_no_more_reads", accept_cnt - a0, 2);
    check_output("t6_no_clear", (clr_cnt0 + clr_cnt1) - (c0 + c1), 0);
    sched_en = 1'b1;
    wait_clears(c0 + c1 + 1, 600, "t6_clear_timeout");
    tick(3);
    check_output("t6_restart_addr", (acc_log.size() > a0 + 2) ? acc_log[a0 + 2] : '1, 26'h100);
    check_output("t6_bursts", accept_cnt - a0, 6);
    check_output("t6_one_clear", clr_cnt0 - c0, 1);

    // Asynchronous reset in the middle of a burst
    reset_dut();
    apply_stimulus(1, 2'b01, 10'd512);
    wait_accepts(a0 + 1, 100, "t7_accept_timeout");
    tick(4);
    check_output("t7_busy_before", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("t7_busy", busy, 0);
    check_output("t7_read", avm_read, 0);
    check_output("t7_addr", avm_address, 0);
    check_output("t7_pix_valid", pix_valid, 0);
    check_output("t7_pix_data", pix_data, 0);
    check_output("t7_cur_buf", cur_buf, 0);
    check_output("t7_clears", {clear_buffer1, clear_buffer0}, 0);

    // Randomised traffic: enable, FIFO space and refills vary freely
    for (int round = 0; round < 3; round++) begin
      reset_dut();
      buffer0_offset = ADDR_W'($urandom);
      buffer1_offset = ADDR_W'($urandom);
      apply_stimulus(1, 2'b11, 10'd512);
      for (int cyc = 0; cyc < 800; cyc++) begin
        tick(1);
        if ($urandom_range(0, 29) == 0) sched_en = !sched_en;
        if ($urandom_range(0, 19) == 0) fifo_space = space_tab[$urandom_range(0, 4)];
        for (int b = 0; b < 2; b++)
          if (!buffer_full[b] && $urandom_range(0, 24) == 0) buffer_full[b] = 1'b1;
      end
      sched_en = 1'b1;
      fifo_space = 10'd512;
      begin
        int n = 0;
        while ((buffer_full != 2'b00 || busy) && n < 3000) begin tick(1); n++; end
      end
      tick(3);
      check_output("rnd_drained", {buffer_full, busy}, 0);
      check_output("rnd_pix_left", pix_q.size(), 0);
      check_output("rnd_clear_left", clr_q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
